// File: rtl/ecc_pkg.sv
// ecc_pkg: shared Hamming(12,8) layout, syndrome, data extraction and encode helpers.
package ecc_pkg;
  localparam int CODE_W = 12;
  localparam int DATA_W = 8;
  localparam int SYN_W = 4;
  localparam int PAR_IDX [SYN_W] = '{0, 1, 3, 7};
  localparam int DATA_IDX [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};
  // Each mask selects the code bits whose Hamming position has that syndrome bit set.
  localparam logic [CODE_W-1:0] SYN_MASK [SYN_W] = '{12'h555, 12'h666, 12'h878, 12'hF80};
  function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CODE_W-1:0] code);
    logic [SYN_W-1:0] s;
    for (int b = 0; b < SYN_W; b++) s[b] = ^(code & SYN_MASK[b]);
    return s;
  endfunction
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DATA_W; k++) d[k] = code[DATA_IDX[k]];
    return d;
  endfunction
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] c;
    logic [SYN_W-1:0] s;
    c = '0;
    for (int k = 0; k < DATA_W; k++) c[DATA_IDX[k]] = data[k];
    s = calc_syndrome(c);
    for (int b = 0; b < SYN_W; b++) c[PAR_IDX[b]] = s[b];
    return c;
  endfunction
endpackage

// File: rtl/ecc_read_decoder_if.sv
// ecc_read_decoder_if: codeword input and decoded result handshake bundle.
interface ecc_read_decoder_if;
  import ecc_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [CODE_W-1:0] in_code;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic out_corrected;
  logic out_uncorrectable;
  logic [SYN_W-1:0] out_syndrome;
  modport slave (
    input in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_corrected, out_uncorrectable, out_syndrome
  );
  modport master (
    output in_valid, in_code, out_ready,
    input in_ready, out_valid, out_data, out_corrected, out_uncorrectable, out_syndrome
  );
endinterface

// File: rtl/ecc_syndrome_fix.sv
// ecc_syndrome_fix: applies a registered syndrome to its codeword, yielding data and status flags.
module ecc_syndrome_fix
  import ecc_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  input  logic [SYN_W-1:0]  i_syn,
  output logic [DATA_W-1:0] o_data,
  output logic              o_corrected,
  output logic              o_uncorrectable
);
  logic w_fixable;
  logic [CODE_W-1:0] w_flip;
  always_comb begin
    w_fixable = (i_syn != '0) && (i_syn <= SYN_W'(CODE_W));
    w_flip = w_fixable ? CODE_W'(1) << (i_syn - SYN_W'(1)) : '0;
    o_data = extract_data(i_code ^ w_flip);
    o_corrected = w_fixable;
    o_uncorrectable = i_syn > SYN_W'(CODE_W);
  end
endmodule

// File: rtl/ecc_read_decoder.sv
// ecc_read_decoder: two-stage Hamming(12,8) SEC decoder with valid/ready flow control
// and saturating corrected/uncorrectable word counters.
module ecc_read_decoder
  import ecc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  ecc_read_decoder_if.slave bus,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);
  logic r_s1_valid;
  logic [CODE_W-1:0] r_s1_code;
  logic [SYN_W-1:0] r_s1_syn;
  logic r_out_valid, r_out_corr, r_out_unc;
  logic [DATA_W-1:0] r_out_data;
  logic [SYN_W-1:0] r_out_syn;
  logic [CNT_W-1:0] r_corr_cnt, r_uncorr_cnt;
  logic w_s2_load, w_in_ready, w_out_hs;
  logic [DATA_W-1:0] w_fix_data;
  logic w_fix_corr, w_fix_unc;
  assign w_s2_load = !r_out_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_out_hs = r_out_valid && bus.out_ready;
  ecc_syndrome_fix u_fix (
    .i_code(r_s1_code),
    .i_syn(r_s1_syn),
    .o_data(w_fix_data),
    .o_corrected(w_fix_corr),
    .o_uncorrectable(w_fix_unc)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_code <= '0;
      r_s1_syn <= '0;
    end else begin
      if (w_in_ready) r_s1_valid <= bus.in_valid;
      if (w_in_ready && bus.in_valid) begin
        r_s1_code <= bus.in_code;
        r_s1_syn <= calc_syndrome(bus.in_code);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_out_corr <= 1'b0;
      r_out_unc <= 1'b0;
      r_out_syn <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_fix_data;
        r_out_corr <= w_fix_corr;
        r_out_unc <= w_fix_unc;
        r_out_syn <= r_s1_syn;
      end
    end
  end
  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_corr_cnt <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      r_corr_cnt <= cnt_clear ? '0 :
                    (w_out_hs && r_out_corr && !(&r_corr_cnt)) ? r_corr_cnt + CNT_W'(1) : r_corr_cnt;
      r_uncorr_cnt <= cnt_clear ? '0 :
                      (w_out_hs && r_out_unc && !(&r_uncorr_cnt)) ? r_uncorr_cnt + CNT_W'(1) : r_uncorr_cnt;
    end
  end
  assign bus.in_ready = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data = r_out_data;
  assign bus.out_corrected = r_out_corr;
  assign bus.out_uncorrectable = r_out_unc;
  assign bus.out_syndrome = r_out_syn;
  assign corr_cnt = r_corr_cnt;
  assign uncorr_cnt = r_uncorr_cnt;
endmodule

// File: tb/tb_ecc_read_decoder.sv
// tb_ecc_read_decoder: randomized scoreboard bench for the Hamming(12,8) read decoder.
module tb_ecc_read_decoder;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int DI [8] = '{2, 4, 5, 6, 8, 9, 10, 11};
  typedef struct packed {
    logic [7:0] d;
    logic c;
    logic u;
    logic [3:0] s;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  logic cnt_clear = 0;
  logic [CW-1:0] corr_cnt, uncorr_cnt;
  exp_t sb[$];
  exp_t prev;
  int checks = 0;
  int errors = 0;
  int m_corr = 0;
  int m_unc = 0;
  int rdy_mode = 0;
  bit stall = 0;
  ecc_read_decoder_if bus ();
  ecc_read_decoder #(.CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .cnt_clear(cnt_clear),
    .corr_cnt(corr_cnt),
    .uncorr_cnt(uncorr_cnt)
  );
  always #5 clk = ~clk;
  // Reference: the syndrome is the XOR of the Hamming positions of all set bits.
  function automatic exp_t model(input logic [11:0] c);
    int s;
    logic [11:0] f;
    exp_t e;
    s = 0;
    for (int i = 0; i < 12; i++) if (c[i]) s ^= i + 1;
    f = c;
    if (s >= 1 && s <= 12) f[s-1] = ~f[s-1];
    for (int k = 0; k < 8; k++) e.d[k] = f[DI[k]];
    e.c = (s >= 1 && s <= 12);
    e.u = (s >= 13);
    e.s = s[3:0];
    return e;
  endfunction
  function automatic logic [11:0] enc(input logic [7:0] d);
    logic [11:0] c;
    int s;
    c = '0;
    s = 0;
    for (int k = 0; k < 8; k++) c[DI[k]] = d[k];
    for (int i = 0; i < 12; i++) if (c[i]) s ^= i + 1;
    for (int b = 0; b < 4; b++) if (s[b]) c[(1 << b) - 1] = 1'b1;
    return c;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, a, e);
    end
  endtask
  task automatic send(input logic [11:0] c);
    bit acc;
    acc = 0;
    bus.in_valid = 1;
    bus.in_code = c;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) sb.push_back(model(c));
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    bus.in_valid = 0;
    bus.in_code = 12'($urandom);
  endtask
  task automatic drain();
    for (int t = 0; t < 500 && sb.size() != 0; t++) @(negedge clk);
    chk("drain_left", sb.size(), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.out_ready = 1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (rdy_mode == 0);
    end
  end
  always @(negedge clk) begin
    exp_t e;
    bit hs;
    if (!rst_n) begin
      stall = 0;
      m_corr = 0;
      m_unc = 0;
      sb.delete();
    end else begin
      hs = bus.out_valid && bus.out_ready;
      e = '0;
      chk("corr_cnt", corr_cnt, m_corr);
      chk("uncorr_cnt", uncorr_cnt, m_unc);
      if (bus.out_valid && stall)
        chk("hold", {bus.out_data, bus.out_corrected, bus.out_uncorrectable, bus.out_syndrome}, prev);
      stall = bus.out_valid && !bus.out_ready;
      prev = {bus.out_data, bus.out_corrected, bus.out_uncorrectable, bus.out_syndrome};
      if (hs) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("out", {bus.out_data, bus.out_corrected, bus.out_uncorrectable, bus.out_syndrome}, e);
        end
      end
      if (cnt_clear) begin
        m_corr = 0;
        m_unc = 0;
      end else if (hs) begin
        if (e.c && m_corr < CMAX) m_corr++;
        if (e.u && m_unc < CMAX) m_unc++;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [11:0] c;
    bus.in_valid = 0;
    bus.in_code = '0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_fields", {bus.out_data, bus.out_corrected, bus.out_uncorrectable, bus.out_syndrome}, 0);
    chk("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    send(12'hA27);
    @(negedge clk);
    chk("lat1_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("lat2_valid", bus.out_valid, 1);
    chk("clean_data", bus.out_data, 8'hA5);
    chk("clean_flags", {bus.out_corrected, bus.out_uncorrectable, bus.out_syndrome}, 0);
    drain();
    chk("clean_cnts", {corr_cnt, uncorr_cnt}, 0);
    send(12'hA07);
    @(negedge clk);
    @(negedge clk);
    chk("single_fields", {bus.out_data, bus.out_corrected, bus.out_uncorrectable, bus.out_syndrome},
        {8'hA5, 1'b1, 1'b0, 4'd6});
    drain();
    chk("single_corr_cnt", corr_cnt, 1);
    send(12'h226);
    @(negedge clk);
    @(negedge clk);
    chk("double_fields", {bus.out_data, bus.out_corrected, bus.out_uncorrectable, bus.out_syndrome},
        {8'h25, 1'b0, 1'b1, 4'd13});
    drain();
    chk("double_uncorr_cnt", uncorr_cnt, 1);
    rdy_mode = 2;
    fork
      for (int i = 0; i < 5; i++) send(enc(8'($urandom)) ^ (i[0] ? 12'h010 : 12'h000));
      begin
        repeat (4) @(posedge clk);
        #1 rdy_mode = 0;
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", bus.in_ready, 0);
      end
    join
    drain();
    rdy_mode = 1;
    for (int n = 0; n < 300; n++) begin
      c = enc(8'($urandom));
      for (int f = $urandom_range(0, 2); f > 0; f--) c[$urandom_range(0, 11)] ^= 1'b1;
      cnt_clear = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(c);
    end
    cnt_clear = 0;
    rdy_mode = 0;
    drain();
    cnt_clear = 1;
    @(posedge clk);
    #1 cnt_clear = 0;
    for (int n = 0; n < 17; n++) send(enc(8'($urandom)) ^ (12'h004 << (n % 4)));
    drain();
    chk("sat_corr_cnt", corr_cnt, CMAX);
    send(12'hA07);
    @(posedge clk);
    #1 cnt_clear = 1;
    @(posedge clk);
    #1 cnt_clear = 0;
    @(negedge clk);
    chk("clear_priority", corr_cnt, 0);
    drain();
    send(12'hA07);
    drain();
    send(12'hA07);
    send(12'h226);
    #2 rst_n = 0;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_cnts", {corr_cnt, uncorr_cnt}, 0);
    chk("async_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    send(12'hA07);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_fields", {bus.out_valid, bus.out_data, bus.out_syndrome}, {1'b1, 8'hA5, 4'd6});
    drain();
    chk("post_rst_corr_cnt", corr_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ecc_read_decoder.md
Name: ecc_read_decoder

Overview:
- Pipelined Hamming(12,8) single-error-correcting decoder on the dual-port memory read path.
- Consumes the 12-bit stored codeword read from a memory port and returns corrected 8-bit data.
- Reports per-word correction and uncorrectable status, and keeps saturating error statistics.
- Uses valid/ready handshakes on both sides, so it can stall under downstream backpressure without loss.

Parameters:
- CNT_W, 16, width of each saturating error counter (legal 4..32).

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  codeword present on in_code
- in_ready  output  1  block accepts in_code this cycle
- in_code  input  12  received codeword (layout below)
- out_valid  output  1  result present on outputs
- out_ready  input  1  downstream accepts result this cycle
- out_data  output  8  corrected data byte
- out_corrected  output  1  single-bit error was corrected in this word
- out_uncorrectable  output  1  syndrome 13..15; out_data is uncorrected raw data
- out_syndrome  output  4  syndrome {s8,s4,s2,s1} of this word
- cnt_clear  input  1  synchronous clear of both counters
- corr_cnt  output  CNT_W  count of corrected words, saturating
- uncorr_cnt  output  CNT_W  count of uncorrectable words, saturating

Behaviour:
- Codeword layout: bit index i = Hamming position i+1.
  - Parity bits at idx 0,1,3,7.
  - Data d0..d7 at idx 2,4,5,6,8,9,10,11.
- Syndrome bits (XOR over received bits):
  - s1 = idx 0,2,4,6,8,10
  - s2 = idx 1,2,5,6,9,10
  - s4 = idx 3,4,5,6,11
  - s8 = idx 7,8,9,10,11
- Syndrome interpretation, S = {s8,s4,s2,s1}:
  - S=0: clean.
  - S in 1..12: flip idx S-1, assert corrected. Parity-bit-only error (S=1,2,4,8) still asserts corrected; data is unchanged.
  - S in 13..15: assert uncorrectable, pass raw data bits.
  - No double-error detection guarantee: a 2-bit error that aliases into 1..12 is miscorrected. This is by design.
- Pipeline:
  - Stage 1 registers in_code and S.
  - Stage 2 registers data, flags and syndrome.
  - Latency: exactly 2 cycles from accept (in_valid&&in_ready) to out_valid with no stall.
  - Throughput: 1 word/cycle.
- Handshake:
  - Stage 2 loads when !out_valid || out_ready.
  - Stage 1 advances under the same condition.
  - in_ready = !s1_valid || stage2_load. in_ready is combinational from out_ready; no skid buffer.
  - Output fields stay stable while out_valid && !out_ready.
  - in_code is ignored when !in_valid.
- Counters:
  - Increment on the output handshake (out_valid && out_ready), never on stall cycles.
  - corr_cnt increments for corrected words; uncorr_cnt increments for uncorrectable words.
  - Each saturates at 2^CNT_W-1.
  - cnt_clear has priority over a same-cycle increment (result 0).
- Reset (async assert, sync-safe deassert):
  - Both stage valids = 0, out_valid = 0.
  - out_data, flags and syndrome = 0.
  - Counters = 0; in_ready = 1 during reset.
  - Reset mid-stream drops in-flight words silently.

Decomposition:
- Package ecc_pkg holds:
  - CODE_W=12, DATA_W=8, SYN_W=4.
  - Localparams for parity and data index positions.
  - Function calc_syndrome(code).
  - Function extract_data(code).
- The encoder side uses the same package.
- One sub-module: ecc_syndrome_fix, combinational. It takes the stage-1 code and syndrome and produces corrected data and flags. It is instantiated between stage 1 and stage 2.

Test Plan:
- Clean word, data 0xA5 = code 0xA27, out_ready=1:
  - out_data=0xA5, S=0, both flags 0.
  - out_valid exactly 2 cycles after accept.
  - Counters unchanged.
- Single data error, code 0xA07 (idx5 flipped):
  - out_data=0xA5, S=6, out_corrected=1.
  - corr_cnt=1.
- Double error, code 0x226 (idx0 and idx11 flipped):
  - S=13, out_uncorrectable=1.
  - out_data = raw extract of 0x226 = 0x25.
  - uncorr_cnt=1.
- Backpressure: 5 back-to-back words with out_ready held 0 for 4 cycles:
  - in_ready falls after 2 words.
  - Outputs hold stable.
  - All 5 words emerge in order with no loss or duplication.
  - Counters count each word once.
- Saturation/clear, CNT_W=4:
  - 17 corrected words give corr_cnt=15.
  - cnt_clear asserted in the same cycle as a corrected handshake gives 0.
- Async reset with 2 words in flight:
  - out_valid=0 immediately (no clock edge needed).
  - Counters=0.
  - First post-reset word decodes correctly.
